led_sweep_monitor: RTL and testbench



---
 rtl/led_sweep_monitor_pkg.sv | 45 ++++
 rtl/led_sweep_expect.sv | 72 +++++++
 rtl/led_sweep_monitor.sv | 151 +++++++++++++++
 tb/tb_led_sweep_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sweep_monitor_pkg.sv
// Shared definitions for the LED sweep monitor.
// Holds the phase encoding, the FSM states and a helper that builds a sweep
// frame from a phase and a sweep index for any LED bus width up to MAX_LED.
package led_sweep_monitor_pkg;

  // Widest LED bus the frame helper can describe.
  localparam int MAX_LED = 64;

  typedef logic [MAX_LED-1:0] wide_frame_t;

  // Phase encoding as seen on the phase output.
  localparam logic [1:0] PH_CLR  = 2'd0;
  localparam logic [1:0] PH_UP   = 2'd1;
  localparam logic [1:0] PH_HOLD = 2'd2;
  localparam logic [1:0] PH_DOWN = 2'd3;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Frame for a given phase and sweep index on an n_led wide bus.
  // CLR is all zeros; every other phase carries the marker bit (n_led-1).
  // UP and HOLD light a single sweep bit; DOWN lights every sweep bit from
  // the index up to the top of the sweep field.
  function automatic wide_frame_t sweep_frame(input int n_led, input logic [1:0] ph,
                                              input int p);
    wide_frame_t f;
    wide_frame_t one;
    f   = '0;
    one = wide_frame_t'(1);
    if (ph != PH_CLR) begin
      f = one << (n_led - 1);
      for (int i = 0; i < MAX_LED - 1; i++) begin
        if (i < n_led - 1) begin
          if ((ph == PH_DOWN && i >= p) || (ph != PH_DOWN && i == p)) begin
            f = f | (one << i);
          end
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/led_sweep_expect.sv
// Expected-frame generator for the LED sweep monitor.
// Purely combinational: turns the current expectation (phase, sweep index,
// hold count) into the LED frame it stands for, and also works out which
// expectation follows it in the canonical lap.
// Ports:
//   phase     in   expected phase (PH_CLR/PH_UP/PH_HOLD/PH_DOWN)
//   pos       in   expected sweep index
//   hold      in   0 for the first HOLD frame, 1 for the second
//   frame     out  expected LED frame
//   nxt_phase out  phase of the frame that follows
//   nxt_pos   out  sweep index of the frame that follows
//   nxt_hold  out  hold count of the frame that follows
module led_sweep_expect #(
  parameter  int N_LED = 26,
  localparam int PW    = $clog2(N_LED - 1)
) (
  input  logic [1:0]       phase,
  input  logic [PW-1:0]    pos,
  input  logic             hold,
  output logic [N_LED-1:0] frame,
  output logic [1:0]       nxt_phase,
  output logic [PW-1:0]    nxt_pos,
  output logic             nxt_hold
);
  import led_sweep_monitor_pkg::*;

  // Top sweep index M.
  localparam logic [PW-1:0] POS_M = PW'(N_LED - 2);

  assign frame = N_LED'(sweep_frame(N_LED, phase, int'(pos)));

  // Successor of the current expectation. HOLD frames sit at index M and use
  // the hold count to tell the first repeat from the second.
  always_comb begin
    nxt_phase = phase;
    nxt_pos   = pos;
    nxt_hold  = hold;
    case (phase)
      PH_CLR: begin
        nxt_phase = PH_UP;
        nxt_pos   = '0;
        nxt_hold  = 1'b0;
      end
      PH_UP: begin
        if (pos == POS_M) begin
          nxt_phase = PH_HOLD;
          nxt_pos   = POS_M;
          nxt_hold  = 1'b0;
        end else begin
          nxt_pos = pos + 1'b1;
        end
      end
      PH_HOLD: begin
        if (!hold) begin
          nxt_hold = 1'b1;
        end else begin
          nxt_phase = PH_DOWN;
          nxt_pos   = POS_M - 1'b1;
          nxt_hold  = 1'b0;
        end
      end
      default: begin
        if (pos == '0) begin
          nxt_phase = PH_CLR;
        end else begin
          nxt_pos = pos - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/led_sweep_monitor.sv
// Receive-side checker for the running-LED sweep pattern.
// Hunts for an all-zero frame, then tracks the canonical lap frame by frame,
// reporting the phase and index of each matched frame, pulsing err on any
// deviation and counting errors (saturating) and completed laps (wrapping).
// All outputs are registered and describe the sample of the previous cycle.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   sample_en in   led is evaluated only while this is high
//   led       in   observed LED vector (bit N_LED-1 is the marker)
//   locked    out  synchronised to the sequence
//   phase     out  phase of the last matched frame
//   pos       out  sweep index of the last matched frame
//   err       out  one-cycle pulse on a mismatch
//   err_cnt   out  saturating mismatch count
//   lap_cnt   out  wrapping completed-lap count
module led_sweep_monitor #(
  parameter  int N_LED = 26,
  parameter  int ERR_W = 8,
  parameter  int LAP_W = 16,
  localparam int PW    = $clog2(N_LED - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N_LED-1:0] led,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [PW-1:0]    pos,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LAP_W-1:0] lap_cnt
);
  import led_sweep_monitor_pkg::*;

  state_t           state_q, state_n;
  logic [1:0]       exp_phase_q, exp_phase_n;
  logic [PW-1:0]    exp_pos_q, exp_pos_n;
  logic             exp_hold_q, exp_hold_n;
  logic [1:0]       phase_q, phase_n;
  logic [PW-1:0]    pos_q, pos_n;
  logic             err_q, err_n;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_n;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_n;

  logic [N_LED-1:0] exp_frame;
  logic [1:0]       nxt_phase;
  logic [PW-1:0]    nxt_pos;
  logic             nxt_hold;

  led_sweep_expect #(
    .N_LED(N_LED)
  ) u_expect (
    .phase    (exp_phase_q),
    .pos      (exp_pos_q),
    .hold     (exp_hold_q),
    .frame    (exp_frame),
    .nxt_phase(nxt_phase),
    .nxt_pos  (nxt_pos),
    .nxt_hold (nxt_hold)
  );

  // State, expectation and report registers; reset wins over sample_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_phase_q <= PH_CLR;
      exp_pos_q   <= '0;
      exp_hold_q  <= 1'b0;
      phase_q     <= PH_CLR;
      pos_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      lap_cnt_q   <= '0;
    end else begin
      state_q     <= state_n;
      exp_phase_q <= exp_phase_n;
      exp_pos_q   <= exp_pos_n;
      exp_hold_q  <= exp_hold_n;
      phase_q     <= phase_n;
      pos_q       <= pos_n;
      err_q       <= err_n;
      err_cnt_q   <= err_cnt_n;
      lap_cnt_q   <= lap_cnt_n;
    end
  end

  // Next-state logic. Everything holds while sample_en is low. A Z frame
  // always (re)locks, whether seen while hunting or as a mismatch while
  // tracking; a matched Z while tracking can only follow D(0), so it closes
  // a lap.
  always_comb begin
    state_n     = state_q;
    exp_phase_n = exp_phase_q;
    exp_pos_n   = exp_pos_q;
    exp_hold_n  = exp_hold_q;
    phase_n     = phase_q;
    pos_n       = pos_q;
    err_n       = 1'b0;
    err_cnt_n   = err_cnt_q;
    lap_cnt_n   = lap_cnt_q;
    if (sample_en) begin
      case (state_q)
        ST_HUNT: begin
          if (led == '0) begin
            state_n     = ST_TRACK;
            exp_phase_n = PH_UP;
            exp_pos_n   = '0;
            exp_hold_n  = 1'b0;
            phase_n     = PH_CLR;
            pos_n       = '0;
          end
        end
        default: begin
          if (led == exp_frame) begin
            phase_n     = exp_phase_q;
            pos_n       = exp_pos_q;
            exp_phase_n = nxt_phase;
            exp_pos_n   = nxt_pos;
            exp_hold_n  = nxt_hold;
            if (exp_phase_q == PH_CLR) begin
              lap_cnt_n = lap_cnt_q + 1'b1;
            end
          end else begin
            err_n = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_n = err_cnt_q + 1'b1;
            end
            if (led == '0) begin
              exp_phase_n = PH_UP;
              exp_pos_n   = '0;
              exp_hold_n  = 1'b0;
              phase_n     = PH_CLR;
              pos_n       = '0;
            end else begin
              state_n = ST_HUNT;
            end
          end
        end
      endcase
    end
  end

  assign locked  = (state_q == ST_TRACK);
  assign phase   = phase_q;
  assign pos     = pos_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_led_sweep_monitor.sv
// Self-checking bench for led_sweep_monitor. A reference model describes the
// lap as a frame index 0..2M+3 and derives frames, phase and position from
// that index arithmetically; the DUT is compared against it every cycle, and
// directed scenarios also pin a few hand-worked values.
module tb_led_sweep_monitor;

  localparam int N_LED   = 26;
  localparam int ERR_W   = 8;
  localparam int LAP_W   = 16;
  localparam int PW      = $clog2(N_LED - 1);
  localparam int M       = N_LED - 2;
  localparam int LAP_LEN = 2 * M + 4;

  typedef logic [N_LED-1:0] frame_t;

  typedef struct packed {
    bit locked;
    int phase;
    int pos;
    bit err;
    int err_cnt;
    int lap;
    int idx;
  } model_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  frame_t           led;
  logic             locked;
  logic [1:0]       phase;
  logic [PW-1:0]    pos;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [LAP_W-1:0] lap_cnt;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     checking = 1'b0;
  model_t m        = '0;

  led_sweep_monitor #(
    .N_LED(N_LED),
    .ERR_W(ERR_W),
    .LAP_W(LAP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .led      (led),
    .locked   (locked),
    .phase    (phase),
    .pos      (pos),
    .err      (err),
    .err_cnt  (err_cnt),
    .lap_cnt  (lap_cnt)
  );

  always #5 clk = ~clk;

  // Frame number idx within a lap: 0 = Z, 1..M+1 = U(0..M),
  // M+2..M+3 = HOLD, M+4..2M+3 = D(M-1..0).
  function automatic frame_t frame_at(input int idx);
    frame_t f;
    frame_t one;
    one = frame_t'(1);
    f   = '0;
    if (idx != 0) begin
      f = one << (N_LED - 1);
      if (idx <= M + 1) f = f | (one << (idx - 1));
      else if (idx <= M + 3) f = f | (one << M);
      else begin
        for (int b = 2 * M + 3 - idx; b <= M; b++) f = f | (one << b);
      end
    end
    return f;
  endfunction

  function automatic int phase_at(input int idx);
    if (idx == 0) return 0;
    if (idx <= M + 1) return 1;
    if (idx <= M + 3) return 2;
    return 3;
  endfunction

  function automatic int pos_at(input int idx);
    if (idx == 0) return 0;
    if (idx <= M + 1) return idx - 1;
    if (idx <= M + 3) return M;
    return 2 * M + 3 - idx;
  endfunction

  // One sampling step of the reference model.
  function automatic model_t model_step(input model_t s, input logic r, input logic en,
                                        input frame_t l);
    model_t n;
    n = s;
    if (r) begin
      n = '0;
      return n;
    end
    n.err = 1'b0;
    if (en) begin
      if (!s.locked) begin
        if (l == '0) begin
          n.locked = 1'b1;
          n.idx    = 1;
          n.phase  = 0;
          n.pos    = 0;
        end
      end else if (l === frame_at(s.idx)) begin
        n.phase = phase_at(s.idx);
        n.pos   = pos_at(s.idx);
        if (s.idx == 0) n.lap = (s.lap + 1) % (1 << LAP_W);
        n.idx = (s.idx + 1) % LAP_LEN;
      end else begin
        n.err = 1'b1;
        if (s.err_cnt < (1 << ERR_W) - 1) n.err_cnt = s.err_cnt + 1;
        if (l == '0) begin
          n.idx   = 1;
          n.phase = 0;
          n.pos   = 0;
        end else begin
          n.locked = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, sample_en, led);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and return on the following falling edge,
  // when the registered outputs describe this sample.
  task automatic applyStimulus(input logic en, input frame_t f);
    sample_en = en;
    led       = f;
    @(negedge clk);
  endtask

  task automatic feedRange(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(1'b1, frame_at(i));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("locked", 32'(locked), 32'(m.locked));
      checkOutput("phase", 32'(phase), 32'(m.phase));
      checkOutput("pos", 32'(pos), 32'(m.pos));
      checkOutput("err", 32'(err), 32'(m.err));
      checkOutput("err_cnt", 32'(err_cnt), 32'(m.err_cnt));
      checkOutput("lap_cnt", 32'(lap_cnt), 32'(m.lap));
    end
  end

  initial begin
    int gen_idx;
    rst       = 1'b1;
    sample_en = 1'b0;
    led       = '0;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checking = 1'b1;
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("reset_lap_cnt", 32'(lap_cnt), 32'd0);
    rst = 1'b0;

    $display("[TB] clean lap");
    applyStimulus(1'b1, frame_at(0));
    checkOutput("lock_after_z", 32'(locked), 32'd1);
    feedRange(1, LAP_LEN - 1);
    checkOutput("d0_phase", 32'(phase), 32'd3);
    checkOutput("d0_pos", 32'(pos), 32'd0);
    checkOutput("clean_err_cnt", 32'(err_cnt), 32'd0);
    applyStimulus(1'b1, frame_at(0));
    checkOutput("first_lap", 32'(lap_cnt), 32'd1);

    $display("[TB] corrupted U(5)");
    feedRange(1, 5);
    applyStimulus(1'b1, frame_at(7));
    checkOutput("corrupt_err", 32'(err), 32'd1);
    checkOutput("corrupt_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("corrupt_unlock", 32'(locked), 32'd0);
    applyStimulus(1'b1, frame_at(8));
    applyStimulus(1'b1, frame_at(30));
    checkOutput("hunt_no_err", 32'(err), 32'd0);
    applyStimulus(1'b1, '0);
    checkOutput("relock", 32'(locked), 32'd1);

    $display("[TB] skipped hold frame");
    feedRange(1, M + 2);
    applyStimulus(1'b1, frame_at(M + 4));
    checkOutput("skip_hold_err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("skip_hold_unlock", 32'(locked), 32'd0);
    applyStimulus(1'b1, '0);

    $display("[TB] sample_en gap mid-DOWN");
    feedRange(1, 41);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, frame_t'($urandom));
    checkOutput("gap_phase", 32'(phase), 32'd3);
    checkOutput("gap_pos", 32'(pos), 32'd10);
    checkOutput("gap_err", 32'(err), 32'd0);
    feedRange(42, LAP_LEN - 1);
    applyStimulus(1'b1, frame_at(0));
    checkOutput("second_lap", 32'(lap_cnt), 32'd2);

    $display("[TB] Z inside UP");
    feedRange(1, 8);
    applyStimulus(1'b1, '0);
    checkOutput("z_err", 32'(err), 32'd1);
    checkOutput("z_locked", 32'(locked), 32'd1);
    checkOutput("z_phase", 32'(phase), 32'd0);
    checkOutput("z_err_cnt", 32'(err_cnt), 32'd3);
    applyStimulus(1'b1, frame_at(1));
    checkOutput("u0_phase", 32'(phase), 32'd1);
    checkOutput("u0_err", 32'(err), 32'd0);

    $display("[TB] randomized traffic");
    gen_idx = 2;
    for (int c = 0; c < 800; c++) begin
      logic   en;
      frame_t f;
      int     r;
      en = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 31);
      if (r < 28) f = frame_at(gen_idx);
      else if (r < 30) f = '0;
      else f = frame_t'($urandom);
      applyStimulus(en, f);
      if (en) begin
        if (r < 28) gen_idx = (gen_idx + 1) % LAP_LEN;
        else if (r < 30) gen_idx = 1;
      end
    end

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, '0);
    checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);
    checkOutput("sat_locked", 32'(locked), 32'd1);

    $display("[TB] reset mid-lap");
    feedRange(1, 10);
    rst = 1'b1;
    applyStimulus(1'b1, frame_at(11));
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_pos", 32'(pos), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_lap_cnt", 32'(lap_cnt), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, frame_at(12));
    checkOutput("post_rst_hunt", 32'(locked), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
